// File: rtl/md_pkg.sv
// Shared types and constants for the iterative M-extension multiply/divide unit.
package md_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } t_md_state;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    localparam int MD_W_ITER = 32;

    function automatic logic is_div(input logic [2:0] func3);
        return func3[2];
    endfunction

endpackage

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negate with optional sign-extension of bit 31,
// shared by operand magnitude preparation and result correction.
module md_sign_fix #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] value,
    input  logic            negate,
    input  logic            word,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] mag;

    always_comb begin
        mag    = negate ? -value : value;
        result = mag;
        if (word) begin
            for (int i = 32; i < XLEN; i++) begin
                result[i] = mag[31];
            end
        end
    end

endmodule

// File: rtl/md_unit.sv
// Iterative radix-2 multiply/divide unit with start/busy/done handshake.
//   state | meaning
//   IDLE  | waiting for i_start; operands latched on acceptance
//   CALC  | one shift-add / shift-subtract step per cycle, counter runs down
//   DONE  | o_result valid, o_done pulses, back to IDLE next cycle
module md_unit
    import md_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [2:0]      i_func3,
    input  logic            i_word,
    input  logic [XLEN-1:0] i_src_1,
    input  logic [XLEN-1:0] i_src_2,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [CW-1:0]   N_FULL    = CW'(XLEN);
    localparam logic [CW-1:0]   N_WORD    = CW'(MD_W_ITER);
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
    localparam logic [XLEN-1:0] ONES      = '1;
    localparam logic [XLEN-1:0] MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] W_MIN_NEG = ~XLEN'(32'h7FFF_FFFF);

    t_md_state state, state_next;

    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] sr, sr_next;
    logic [XLEN-1:0]   op_b;
    logic [2:0]        f_q;
    logic              word_q, a_neg_q, q_neg_q;

    logic [2:0]      f_eff;
    logic            a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] special_val;

    // W forms of MULH/MULHSU/MULHU do not exist; they execute as MULW.
    always_comb begin
        f_eff    = (i_word && !i_func3[2]) ? MD_MUL : i_func3;
        a_signed = f_eff inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
        b_signed = f_eff inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
        a_ext    = i_src_1;
        b_ext    = i_src_2;
        if (i_word) begin
            for (int i = 32; i < XLEN; i++) begin
                a_ext[i] = a_signed & i_src_1[31];
                b_ext[i] = b_signed & i_src_2[31];
            end
        end
        a_neg = a_signed & a_ext[XLEN-1];
        b_neg = b_signed & b_ext[XLEN-1];
    end

    md_sign_fix #(.XLEN(XLEN)) u_mag_a (.value(a_ext), .negate(a_neg), .word(1'b0), .result(a_mag));
    md_sign_fix #(.XLEN(XLEN)) u_mag_b (.value(b_ext), .negate(b_neg), .word(1'b0), .result(b_mag));

    always_comb begin
        div_zero = is_div(f_eff) && (b_ext == '0);
        div_ovf  = (f_eff == MD_DIV || f_eff == MD_REM) && (b_ext == ONES)
                   && (a_ext == (i_word ? W_MIN_NEG : MIN_NEG));
        special  = div_zero || div_ovf;
        if (f_eff[1]) special_val = div_zero ? a_ext : '0;
        else          special_val = div_zero ? ONES  : a_ext;
    end

    // Multiply shifts right with the multiplier in the low half; divide shifts
    // left with the remainder in the high half and quotient bits entering at bit 0.
    logic [XLEN:0] mul_sum, div_diff;

    always_comb begin
        mul_sum  = {1'b0, sr[2*XLEN-1:XLEN]} + (sr[0] ? {1'b0, op_b} : '0);
        div_diff = sr[2*XLEN-1:XLEN-1] - {1'b0, op_b};
        if (is_div(f_q)) begin
            sr_next = div_diff[XLEN] ? {sr[2*XLEN-2:0], 1'b0}
                                     : {div_diff[XLEN-1:0], sr[XLEN-2:0], 1'b1};
        end else begin
            sr_next = {mul_sum, sr[XLEN-1:1]};
        end
    end

    logic [XLEN-1:0] prod_hi, prod_lo, mulh_res, calc_res;
    logic [XLEN-1:0] fix_value, fix_out;
    logic            fix_neg, fix_word;

    always_comb begin
        prod_hi   = sr_next[2*XLEN-1:XLEN];
        prod_lo   = sr_next[XLEN-1:0];
        // High half of a negated 2N-bit product: borrow only when the low half is zero.
        mulh_res  = q_neg_q ? (~prod_hi + {{(XLEN-1){1'b0}}, (prod_lo == '0)}) : prod_hi;
        fix_value = prod_lo;
        fix_neg   = q_neg_q;
        fix_word  = word_q;
        if (state == ST_IDLE) begin
            fix_value = special_val;
            fix_neg   = 1'b0;
            fix_word  = i_word;
        end else if (is_div(f_q)) begin
            fix_value = f_q[1] ? prod_hi : prod_lo;
            fix_neg   = f_q[1] ? a_neg_q : q_neg_q;
        end else if (word_q) begin
            fix_value       = '0;
            fix_value[31:0] = sr_next[XLEN-1 -: 32];
        end
    end

    md_sign_fix #(.XLEN(XLEN)) u_res_fix (.value(fix_value), .negate(fix_neg), .word(fix_word), .result(fix_out));

    assign calc_res = (!is_div(f_q) && f_q != MD_MUL) ? mulh_res : fix_out;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (i_start) state_next = special ? ST_DONE : ST_CALC;
            ST_CALC: if (cnt == CNT_ONE) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            sr       <= '0;
            op_b     <= '0;
            f_q      <= '0;
            word_q   <= 1'b0;
            a_neg_q  <= 1'b0;
            q_neg_q  <= 1'b0;
            o_result <= '0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        f_q     <= f_eff;
                        word_q  <= i_word;
                        a_neg_q <= a_neg;
                        q_neg_q <= a_neg ^ b_neg;
                        op_b    <= b_mag;
                        cnt     <= i_word ? N_WORD : N_FULL;
                        // W dividends sit at the top so 32 steps consume all their bits.
                        sr      <= {{XLEN{1'b0}},
                                    (is_div(f_eff) && i_word) ? (a_mag << (XLEN - MD_W_ITER)) : a_mag};
                        if (special) o_result <= fix_out;
                    end
                end
                ST_CALC: begin
                    sr  <= sr_next;
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) o_result <= calc_res;
                end
                default: ;
            endcase
        end
    end

    assign o_busy = (state != ST_IDLE);
    assign o_done = (state == ST_DONE);

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit (XLEN=64): latency, results, special cases,
// ignored starts and mid-operation reset.
module tb_md_unit;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic [2:0]  i_func3;
    logic        i_word;
    logic [63:0] i_src_1, i_src_2;
    logic        o_busy, o_done;
    logic [63:0] o_result;

    int checks = 0;
    int errors = 0;

    md_unit #(.XLEN(64)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_func3(i_func3),
        .i_word(i_word), .i_src_1(i_src_1), .i_src_2(i_src_2),
        .o_busy(o_busy), .o_done(o_done), .o_result(o_result)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Start at the next edge (edge 0), then wait for o_done counting cycles.
    task automatic run_op(input string tag, input logic [2:0] f, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input int exp_cyc, input bit noise);
        int cyc;
        int busy_lo;
        i_func3 = f; i_word = w; i_src_1 = a; i_src_2 = b; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        cyc = 1;
        busy_lo = 0;
        while (!o_done && cyc < 200) begin
            if (!o_busy) busy_lo++;
            i_start = noise && (cyc == 10 || cyc == 30);
            if (i_start) begin
                i_func3 = 3'b000; i_word = 1'b0;
                i_src_1 = 64'hDEAD_BEEF; i_src_2 = 64'h3;
            end
            @(posedge i_clk); #1;
            cyc++;
        end
        i_start = 1'b0;
        chk({tag, "_latency"}, 64'(cyc), 64'(exp_cyc));
        chk({tag, "_busy_gap"}, 64'(busy_lo), 64'd0);
        chk({tag, "_busy_in_done"}, 64'(o_busy), 64'd1);
        chk({tag, "_result"}, o_result, exp);
        @(posedge i_clk); #1;
        chk({tag, "_idle_after"}, {62'd0, o_busy, o_done}, 64'd0);
        chk({tag, "_hold"}, o_result, exp);
    endtask

    initial begin
        int dones;
        i_rst = 1'b1; i_start = 1'b0; i_func3 = 3'b000; i_word = 1'b0;
        i_src_1 = '0; i_src_2 = '0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("reset_outputs", {o_busy, o_done, o_result[61:0]}, 64'd0);
        chk("reset_result", o_result, 64'd0);
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        chk("post_reset_idle", {62'd0, o_busy, o_done}, 64'd0);

        run_op("mul_7x-3",     3'b000, 1'b0, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 65, 1'b0);
        run_op("mulhu_max_x2", 3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 65, 1'b0);
        run_op("mulhsu_-1x2",  3'b010, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 1'b0);
        run_op("mulh_pos",     3'b001, 1'b0, 64'h4000_0000_0000_0000, 64'd4, 64'd1, 65, 1'b0);
        run_op("mulh_min_x2",  3'b001, 1'b0, 64'h8000_0000_0000_0000, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 1'b0);
        run_op("mulh_-2x3",    3'b001, 1'b0, -64'sd2, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 65, 1'b0);

        run_op("div_-20_6",    3'b100, 1'b0, -64'sd20, 64'd6, 64'hFFFF_FFFF_FFFF_FFFD, 65, 1'b0);
        run_op("rem_-20_6",    3'b110, 1'b0, -64'sd20, 64'd6, 64'hFFFF_FFFF_FFFF_FFFE, 65, 1'b0);
        run_op("rem_20_-6",    3'b110, 1'b0, 64'd20, -64'sd6, 64'd2, 65, 1'b0);
        run_op("divu_100_7",   3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 65, 1'b0);
        run_op("remu_100_7",   3'b111, 1'b0, 64'd100, 64'd7, 64'd2, 65, 1'b0);
        run_op("divu_min_-1",  3'b101, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 65, 1'b0);

        run_op("remuw",        3'b111, 1'b1, 64'h1_0000_0009, 64'd4, 64'd1, 33, 1'b0);
        run_op("divw_-20_6",   3'b100, 1'b1, -64'sd20, 64'd6, 64'hFFFF_FFFF_FFFF_FFFD, 33, 1'b0);
        run_op("divuw_sext",   3'b101, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 33, 1'b0);
        run_op("mulw",         3'b000, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33, 1'b0);
        run_op("mulw_f001",    3'b001, 1'b1, 64'd3, -64'sd5, 64'hFFFF_FFFF_FFFF_FFF1, 33, 1'b0);

        run_op("div_by_zero",  3'b100, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b0);
        run_op("rem_by_zero",  3'b110, 1'b0, 64'd5, 64'd0, 64'd5, 1, 1'b0);
        run_op("div_ovf",      3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1, 1'b0);
        run_op("rem_ovf",      3'b110, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 1'b0);
        run_op("divw_ovf",     3'b100, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, 1'b0);
        run_op("divuw_by_zero",3'b101, 1'b1, 64'd7, 64'h1_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b0);
        run_op("remuw_by_zero",3'b111, 1'b1, 64'h8000_0005, 64'd0, 64'hFFFF_FFFF_8000_0005, 1, 1'b0);

        run_op("divu_ignored_starts", 3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 65, 1'b1);

        // Reset in cycle 20 of a DIV.
        i_func3 = 3'b100; i_word = 1'b0; i_src_1 = 64'd1000; i_src_2 = 64'd7; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        repeat (19) begin @(posedge i_clk); #1; end
        chk("busy_before_reset", 64'(o_busy), 64'd1);
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        chk("reset_mid_flags", {62'd0, o_busy, o_done}, 64'd0);
        chk("reset_mid_result", o_result, 64'd0);
        dones = 0;
        repeat (80) begin
            @(posedge i_clk); #1;
            if (o_done) dones++;
        end
        chk("no_done_after_reset", 64'(dones), 64'd0);
        run_op("mul_3x4_after_reset", 3'b000, 1'b0, 64'd3, 64'd4, 64'd12, 65, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/md_unit.md
# md_unit

Iterative RV64 M-extension multiply/divide unit, parametrised in operand width, serving the execute stage next to the ALU. Executes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU and the W forms MULW, DIVW, DIVUW, REMW, REMUW. Uses one radix-2 iteration per cycle with a start/busy/done handshake, so the pipeline stalls on `o_busy`. Division-by-zero and signed-overflow cases bypass iteration.

## Interface
- XLEN, 64, operand/result width; must be even and ≥ 32. W forms always operate on 32 bits.
- i_clk  in  1  clock; all state updates on its rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_start  in  1  request; sampled only in IDLE.
- i_func3  in  3  M-extension funct3.
- i_word  in  1  1 = W form (opcode OP-32).
- i_src_1  in  XLEN  rs1 operand.
- i_src_2  in  XLEN  rs2 operand.
- o_busy  out  1  high in CALC and DONE.
- o_done  out  1  single-cycle pulse, high in DONE.
- o_result  out  XLEN  result; valid while o_done = 1 and held until the next accepted start.

## Operation
- States: IDLE, CALC, DONE.
- IDLE with i_start = 1 latches func3, word, operands and enters CALC. A special case enters DONE directly.
- `i_start` outside IDLE is ignored. There is no queueing.
- CALC runs a fixed count of N iterations, then enters DONE. N = XLEN for normal forms and N = 32 for W forms.
- DONE always returns to IDLE after one cycle.
- Operand preparation:
  - W forms take bits [31:0] of each operand.
  - Signed ops (MUL*, DIV, REM, MULH, the rs1 side of MULHSU, DIVW, REMW) convert operands to magnitudes and record the result sign.
- Multiply:
  - Shift-add over N multiplier bits produces a 2N-bit magnitude product, which is then sign-corrected.
  - MUL/MULW take the low N bits; the MULH family takes the high XLEN bits.
- Divide:
  - Restoring shift-subtract, one quotient bit per iteration.
  - The quotient takes the sign of (rs1 xor rs2).
  - The remainder takes the sign of the dividend.
- W results are the 32-bit value sign-extended to XLEN. This applies to DIVUW and REMUW as well.
- i_word = 1 with func3 ∈ {001, 010, 011} executes as MULW.
- Special cases, each taking 1 cycle to DONE:
  - Divisor = 0: quotient = all ones (−1); remainder = dividend.
  - Signed overflow, i.e. dividend = most-negative and divisor = −1 (DIV/REM/DIVW/REMW): quotient = dividend; remainder = 0.
- Reset in any state forces IDLE immediately and discards the operation in flight.

## Timing
- Reset values: state = IDLE, o_busy = 0, o_done = 0, o_result = 0, counter = 0, accumulators = 0.
- Let edge 0 be the edge where the start is accepted.
- Normal latency: CALC occupies cycles 1..N, DONE is cycle N+1, so o_done is high exactly in cycle N+1.
  - XLEN=64 non-W: 65 cycles from start to done.
  - W forms: 33 cycles.
- Special-case latency: DONE is cycle 1.
- o_busy rises in cycle 1 and falls in cycle N+2, when the unit is back in IDLE.
- A new start is accepted in the first IDLE cycle after DONE. Back-to-back throughput is N+2 cycles per operation.
- o_result changes only on the edge that enters DONE.
- Reset asserted in cycle k (1 ≤ k ≤ N+1): in cycle k+1 the unit is in IDLE with all outputs 0, and no o_done pulse occurs.

## Structure
- Shared package `md_pkg` holds:
  - the state enum `t_md_state`;
  - funct3 localparams (MD_MUL … MD_REMU);
  - the W iteration count constant (32).
- One natural sub-module: `md_sign_fix`, the combinational magnitude/negate and W sign-extension logic. It is instantiated for operand preparation and for result correction.
- The top-level holds the FSM, the iteration counter (width $clog2(XLEN+1)) and the 2·XLEN shift register.

## Test plan
- MUL 7 × −3 (XLEN=64): o_done in cycle 65, result 0xFFFF_FFFF_FFFF_FFEB; o_busy high in cycles 1–65.
- MULHU 0xFFFF_FFFF_FFFF_FFFF × 2 → 0x1. MULHSU −1 × 2 → 0xFFFF_FFFF_FFFF_FFFF.
- DIV −20 / 6 → −3; REM −20 / 6 → −2; DIVU 100 / 7 → 14; REMUW 0x1_0000_0009 % 4 → 1. W forms finish in cycle 33.
- Special cases, each with o_done in cycle 1:
  - DIV 5 / 0 → 0xFFFF_FFFF_FFFF_FFFF;
  - REM 5 / 0 → 5;
  - DIV 0x8000_0000_0000_0000 / −1 → 0x8000_0000_0000_0000 with REM → 0;
  - DIVW 0x8000_0000 / −1 → 0xFFFF_FFFF_8000_0000.
- Start pulses in cycles 10 and 30 during a busy operation are ignored. The result equals that of the first op alone, and the next accepted start follows DONE.
- i_rst in cycle 20 of a DIV: IDLE in cycle 21 with all outputs 0 and no o_done. A fresh MUL 3 × 4 then returns 12 after 65 cycles.
